interval_timer: RTL and testbench

Programmable down-counting interval timer with prescaler, one-shot/periodic modes and a sticky interrupt with acknowledge handshake. It consumes a loaded count rather than producing one: software-visible control (start/stop/reload value) enters from the CSR/peripheral side, and `irq` feeds the core's interrupt logic. It is the event-generating counterpart to the free-running counter primitives in the primitive cell library.

---
 rtl/interval_timer_pkg.sv | 9 +
 rtl/interval_timer_if.sv | 29 ++
 rtl/interval_timer_prescaler.sv | 50 +++++
 rtl/interval_timer.sv | 138 +++++++++++++
 tb/tb_interval_timer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/interval_timer_pkg.sv
// Shared types for the interval timer: FSM state encoding.
package timer_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_t;

endpackage : timer_pkg

// File: rtl/interval_timer_if.sv
// Control/status bundle between the CSR side and the interval timer.
interface interval_timer_if #(
    parameter int WIDTH      = 32,
    parameter int PRESCALE_W = 8
);
    logic                  start;
    logic                  stop;
    logic                  periodic;
    logic [WIDTH-1:0]      load_val;
    logic [PRESCALE_W-1:0] prescale;
    logic                  irq_ack;
    logic [WIDTH-1:0]      count;
    logic                  busy;
    logic                  expired;
    logic                  irq;
    logic                  overrun;

    // CSR / software side drives control, observes status
    modport master (
        output start, stop, periodic, load_val, prescale, irq_ack,
        input  count, busy, expired, irq, overrun
    );

    // Timer side consumes control, produces status
    modport slave (
        input  start, stop, periodic, load_val, prescale, irq_ack,
        output count, busy, expired, irq, overrun
    );
endinterface : interval_timer_if

// File: rtl/interval_timer_prescaler.sv
// Prescale down-counter: emits a tick every (prescale+1) enabled clocks.
// The divider value is captured on restart and reused on every reload.
module interval_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  restart_i,
    input  logic                  en_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  tick_o
);
    localparam logic [PRESCALE_W-1:0] PS_ZERO = {PRESCALE_W{1'b0}};
    localparam logic [PRESCALE_W-1:0] PS_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic [PRESCALE_W-1:0] reload_q, reload_d;

    // Tick is due whenever the counter has run down while enabled
    assign tick_o = en_i && (cnt_q == PS_ZERO);

    // Next-state: restart loads the new divider, otherwise count down and wrap
    always_comb begin
        cnt_d    = cnt_q;
        reload_d = reload_q;
        if (restart_i) begin
            cnt_d    = prescale_i;
            reload_d = prescale_i;
        end else if (en_i) begin
            if (cnt_q == PS_ZERO) begin
                cnt_d = reload_q;
            end else begin
                cnt_d = cnt_q - PS_ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Prescaler state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= PS_ZERO;
            reload_q <= PS_ZERO;
        end else begin
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
        end
    end
endmodule : interval_prescaler

// File: rtl/interval_timer.sv
// Programmable down-counting interval timer with one-shot/periodic modes,
// sticky interrupt and overrun flag. stop beats start beats tick.
module interval_timer
    import timer_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int PRESCALE_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    interval_timer_if.slave  bus
);
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    timer_state_t     state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             busy_q;
    logic             expired_q;
    logic             irq_q, irq_d;
    logic             overrun_q, overrun_d;
    logic             expire_s;
    logic             tick_s;
    logic             restart_s;
    logic             ps_en_s;

    // A real (non-zero) start restarts the prescaler; a stop freezes it
    assign restart_s = bus.start && !bus.stop && (bus.load_val != CNT_ZERO);
    assign ps_en_s   = (state_q == RUN) && !bus.stop;

    interval_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk        (clk),
        .rst_n      (rst_n),
        .restart_i  (restart_s),
        .en_i       (ps_en_s),
        .prescale_i (bus.prescale),
        .tick_o     (tick_s)
    );

    // FSM next-state, count update and expiry detection
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        expire_s = 1'b0;
        if (bus.stop) begin
            state_d = IDLE;
        end else if (bus.start) begin
            if (bus.load_val == CNT_ZERO) begin
                expire_s = 1'b1;
                count_d  = CNT_ZERO;
                state_d  = IDLE;
            end else begin
                reload_d = bus.load_val;
                mode_d   = bus.periodic;
                count_d  = bus.load_val;
                state_d  = RUN;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (!tick_s) begin
                        count_d = count_q;
                    end else if (count_q > CNT_ONE) begin
                        count_d = count_q - CNT_ONE;
                    end else begin
                        expire_s = 1'b1;
                        if (mode_q) begin
                            count_d = reload_q;
                        end else begin
                            count_d = CNT_ZERO;
                            state_d = IDLE;
                        end
                    end
                end
                IDLE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Sticky interrupt/overrun: a coincident expiry wins over acknowledge
    always_comb begin
        irq_d     = irq_q;
        overrun_d = overrun_q;
        if (bus.irq_ack) begin
            irq_d     = 1'b0;
            overrun_d = 1'b0;
        end else begin
            irq_d     = irq_q;
            overrun_d = overrun_q;
        end
        if (expire_s) begin
            irq_d = 1'b1;
            if (irq_q && !bus.irq_ack) begin
                overrun_d = 1'b1;
            end else begin
                overrun_d = overrun_d;
            end
        end else begin
            irq_d = irq_d;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= CNT_ZERO;
            reload_q  <= CNT_ZERO;
            mode_q    <= 1'b0;
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
            irq_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            mode_q    <= mode_d;
            busy_q    <= (state_d == RUN);
            expired_q <= expire_s;
            irq_q     <= irq_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.count   = count_q;
    assign bus.busy    = busy_q;
    assign bus.expired = expired_q;
    assign bus.irq     = irq_q;
    assign bus.overrun = overrun_q;
endmodule : interval_timer

// File: tb/tb_interval_timer.sv
// Scoreboard bench for interval_timer: a time-based reference model predicts
// the outputs after every edge; a monitor pops and compares independently.
module tb_interval_timer;
    localparam int W  = 32;
    localparam int PW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    interval_timer_if #(.WIDTH(W), .PRESCALE_W(PW)) bus ();

    interval_timer #(.WIDTH(W), .PRESCALE_W(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [W-1:0] count;
        logic         busy;
        logic         expired;
        logic         irq;
        logic         overrun;
    } obs_t;

    obs_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: a run is described by its start edge, N, P and mode;
    // the count at any edge follows from elapsed time alone.
    bit m_run, m_per;
    int m_t0, m_n, m_p, m_idle;
    bit m_irq, m_ovr;
    int t = 0;

    function automatic int cnt_at(int tt);
        int e, k;
        if (!m_run) return m_idle;
        e = tt - m_t0;
        k = e / (m_p + 1);
        if (m_per) return m_n - (k % m_n);
        return (k < m_n) ? (m_n - k) : 0;
    endfunction

    task automatic step(input bit st, input bit sp, input bit per,
                        input int lv, input int ps, input bit ack);
        bit   ex;
        bit   old_irq;
        int   e;
        obs_t o;
        bus.start    = st;
        bus.stop     = sp;
        bus.periodic = per;
        bus.load_val = W'(lv);
        bus.prescale = PW'(ps);
        bus.irq_ack  = ack;
        t  = t + 1;
        ex = 1'b0;
        if (sp) begin
            if (m_run) begin
                m_idle = cnt_at(t - 1);
                m_run  = 1'b0;
            end
        end else if (st) begin
            if (lv == 0) begin
                ex     = 1'b1;
                m_run  = 1'b0;
                m_idle = 0;
            end else begin
                m_run = 1'b1;
                m_t0  = t;
                m_n   = lv;
                m_p   = ps;
                m_per = per;
            end
        end else if (m_run) begin
            e = t - m_t0;
            if (e > 0 && (e % (m_p + 1)) == 0 && ((e / (m_p + 1)) % m_n) == 0) begin
                ex = 1'b1;
                if (!m_per) begin
                    m_run  = 1'b0;
                    m_idle = 0;
                end
            end
        end
        old_irq = m_irq;
        if (ack) begin
            m_irq = 1'b0;
            m_ovr = 1'b0;
        end
        if (ex) begin
            if (old_irq && !ack) m_ovr = 1'b1;
            m_irq = 1'b1;
        end
        o.count   = W'(cnt_at(t));
        o.busy    = m_run;
        o.expired = ex;
        o.irq     = m_irq;
        o.overrun = m_ovr;
        exp_q.push_back(o);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic rand_steps(input int n);
        for (int i = 0; i < n; i++) begin
            step(($urandom % 24) == 0, ($urandom % 50) == 0, $urandom % 2,
                 (($urandom % 8) == 0) ? 0 : int'($urandom_range(1, 6)),
                 int'($urandom_range(0, 3)), ($urandom % 10) == 0);
        end
    endtask

    // Asynchronous reset: outputs must clear without waiting for an edge
    task automatic check_reset(input string name);
        obs_t got;
        rst_n = 1'b0;
        #1;
        got = {bus.count, bus.busy, bus.expired, bus.irq, bus.overrun};
        tests++;
        if (got != '0) begin
            fails++;
            $display("FAIL %s got count=%0d busy=%0b expired=%0b irq=%0b overrun=%0b, expected all zero",
                     name, got.count, got.busy, got.expired, got.irq, got.overrun);
        end
        m_run  = 1'b0;
        m_idle = 0;
        m_irq  = 1'b0;
        m_ovr  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: after each edge, compare DUT outputs with the next prediction
    obs_t mon_exp, mon_got;
    always @(posedge clk) begin
        #1;
        if (rst_n && exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_got = {bus.count, bus.busy, bus.expired, bus.irq, bus.overrun};
            tests++;
            if (mon_got !== mon_exp) begin
                fails++;
                $display("FAIL outputs t=%0d got count=%0d busy=%0b expired=%0b irq=%0b overrun=%0b expected count=%0d busy=%0b expired=%0b irq=%0b overrun=%0b",
                         t, mon_got.count, mon_got.busy, mon_got.expired, mon_got.irq, mon_got.overrun,
                         mon_exp.count, mon_exp.busy, mon_exp.expired, mon_exp.irq, mon_exp.overrun);
            end
        end
    end

    initial begin
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.periodic = 1'b0;
        bus.load_val = '0;
        bus.prescale = '0;
        bus.irq_ack  = 1'b0;
        m_run = 1'b0; m_per = 1'b0; m_t0 = 0; m_n = 1; m_p = 0; m_idle = 0;
        m_irq = 1'b0; m_ovr = 1'b0;
        @(negedge clk);
        check_reset("reset_state");
        idle(2);
        // One-shot N=3 P=0, then acknowledge
        step(1'b1, 1'b0, 1'b0, 3, 0, 1'b0);
        idle(5);
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        idle(1);
        // Periodic N=2 P=2: two unacked expiries give overrun, ack clears
        step(1'b1, 1'b0, 1'b1, 2, 2, 1'b0);
        idle(14);
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        idle(2);
        // Ack on the same edge as an expiry
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        idle(5);
        // Stop on the expiry-due edge with count=1
        step(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        idle(3);
        // Restart with N=4 while running at count=2
        step(1'b1, 1'b0, 1'b1, 5, 1, 1'b0);
        idle(6);
        step(1'b1, 1'b0, 1'b0, 4, 1, 1'b0);
        idle(10);
        // Zero load value: immediate expiry, stays idle
        step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        idle(2);
        rand_steps(3000);
        // Reset mid-run at count=5
        step(1'b1, 1'b0, 1'b0, 9, 0, 1'b0);
        idle(4);
        check_reset("reset_mid_run");
        step(1'b1, 1'b0, 1'b1, 3, 1, 1'b0);
        idle(12);
        rand_steps(500);
        idle(2);
        @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule : tb_interval_timer
